// File: rtl/latch_load_sequencer.sv
// latch_load_sequencer: serial-in word collector that drives a D-latch
// bank through a setup / enable / hold window around latch_enable.
module latch_load_sequencer #(
  parameter int WIDTH        = 8,
  parameter int SETUP_CYCLES = 1,
  parameter int EN_CYCLES    = 2,
  parameter int HOLD_CYCLES  = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             s_valid,
  input  logic             s_data,
  output logic             s_ready,
  input  logic             clear,
  output logic [WIDTH-1:0] latch_D,
  output logic             latch_enable,
  output logic             busy,
  output logic             done
);

  localparam int SE_MAX = (SETUP_CYCLES > EN_CYCLES)
                        ? SETUP_CYCLES : EN_CYCLES;
  localparam int T_MAX  = (SE_MAX > HOLD_CYCLES)
                        ? SE_MAX : HOLD_CYCLES;
  localparam int TW     = $clog2(T_MAX + 1);
  localparam int CW     = $clog2(WIDTH + 1);

  localparam logic [1:0] COLLECT = 2'd0;
  localparam logic [1:0] SETUP   = 2'd1;
  localparam logic [1:0] ENABLE  = 2'd2;
  localparam logic [1:0] HOLD    = 2'd3;

  localparam logic [TW-1:0] T_SETUP = TW'(SETUP_CYCLES - 1);
  localparam logic [TW-1:0] T_EN    = TW'(EN_CYCLES - 1);
  localparam logic [TW-1:0] T_HOLD  = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] T_ONE   = TW'(1);
  localparam logic [CW-1:0] C_LAST  = CW'(WIDTH - 1);
  localparam logic [CW-1:0] C_ONE   = CW'(1);

  logic [1:0]       state;
  logic [1:0]       state_nx;
  logic [TW-1:0]    timer;
  logic [TW-1:0]    timer_nx;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] word;

  logic in_collect;
  logic accept;
  logic purge;
  logic last_bit;
  logic t_zero;
  logic enter_en;
  logic enter_hold;
  logic leave_hold;

  assign in_collect = (state == COLLECT);
  assign purge      = in_collect && clear;
  assign accept     = in_collect && s_valid
                   && s_ready && !clear;
  assign last_bit   = accept && (count == C_LAST);
  assign t_zero     = (timer == '0);
  assign enter_en   = (state == SETUP)  && t_zero;
  assign enter_hold = (state == ENABLE) && t_zero;
  assign leave_hold = (state == HOLD)   && t_zero;
  assign word       = {shreg[WIDTH-2:0], s_data};

  // Phase sequencing: each window ends when its timer reaches zero.
  always_comb begin
    state_nx = state;
    unique case (state)
      COLLECT: if (last_bit)   state_nx = SETUP;
      SETUP:   if (enter_en)   state_nx = ENABLE;
      ENABLE:  if (enter_hold) state_nx = HOLD;
      HOLD:    if (leave_hold) state_nx = COLLECT;
      default:                 state_nx = COLLECT;
    endcase
  end

  // Phase timer: loaded with length-1 on entry, counts down to zero.
  always_comb begin
    timer_nx = timer;
    unique case (1'b1)
      last_bit:   timer_nx = T_SETUP;
      enter_en:   timer_nx = T_EN;
      enter_hold: timer_nx = T_HOLD;
      (!in_collect && !t_zero):
                  timer_nx = timer - T_ONE;
      default:    timer_nx = timer;
    endcase
  end

  // State and timer registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= COLLECT;
      timer <= '0;
    end else begin
      state <= state_nx;
      timer <= timer_nx;
    end
  end

  // Serial collection; clear wins over a bit offered in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
      shreg <= '0;
    end else if (purge || last_bit) begin
      count <= '0;
      shreg <= '0;
    end else if (accept) begin
      count <= count + C_ONE;
      shreg <= word;
    end
  end

  // Parallel word only moves on the COLLECT->SETUP edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      latch_D <= '0;
    end else if (last_bit) begin
      latch_D <= word;
    end
  end

  // Enable window spans exactly the ENABLE phase.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      latch_enable <= 1'b0;
    end else if (enter_en) begin
      latch_enable <= 1'b1;
    end else if (enter_hold) begin
      latch_enable <= 1'b0;
    end
  end

  // Handshake and status flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_ready <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= leave_hold;
      if (last_bit) begin
        s_ready <= 1'b0;
        busy    <= 1'b1;
      end else if (leave_hold) begin
        s_ready <= 1'b1;
        busy    <= 1'b0;
      end else if (in_collect) begin
        s_ready <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_latch_load_sequencer.sv
// tb_latch_load_sequencer: randomized stimulus with a queue scoreboard
// and an arithmetic timing model of the load window.
module tb_latch_load_sequencer;

  localparam int W   = 8;
  localparam int S   = 1;
  localparam int E   = 2;
  localparam int H   = 1;
  localparam int WIN = S + E + H;

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic         s_valid = 1'b0;
  logic         s_data = 1'b0;
  logic         clear = 1'b0;
  logic         s_ready;
  logic         latch_enable;
  logic         busy;
  logic         done;
  logic [W-1:0] latch_D;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  logic [W-1:0] exp_q[$];
  bit           bits_q[$];
  int           k_hist[$];
  int           last_k = 0;
  bit           kv = 1'b0;
  bit           seen_edge = 1'b0;
  bit           prev_en = 1'b0;
  logic [W-1:0] model_latch = '0;

  latch_load_sequencer #(
    .WIDTH(W), .SETUP_CYCLES(S),
    .EN_CYCLES(E), .HOLD_CYCLES(H)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .s_valid(s_valid),
    .s_data(s_data),
    .s_ready(s_ready),
    .clear(clear),
    .latch_D(latch_D),
    .latch_enable(latch_enable),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk_b(input string nm,
                       input logic got,
                       input logic exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b (cycle %0d)",
                  nm, got, exp, cyc);
  endtask

  task automatic chk_w(input string nm,
                       input logic [W-1:0] got,
                       input logic [W-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)",
                  nm, got, exp, cyc);
  endtask

  task automatic chk_i(input string nm, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
  endtask

  // Reference model: accepted bits form words MSB first; a word
  // completes on the edge taking its W-th bit.
  always @(posedge clk) begin
    int e;
    logic [W-1:0] w;
    e = cyc;
    if (reset_n) begin
      if (clear && s_ready) begin
        bits_q.delete();
      end else if (s_valid && s_ready) begin
        bits_q.push_back(s_data);
        if (bits_q.size() == W) begin
          w = '0;
          foreach (bits_q[i]) w = {w[W-2:0], bits_q[i]};
          exp_q.push_back(w);
          model_latch = w;
          last_k = e;
          kv = 1'b1;
          k_hist.push_back(e);
          bits_q.delete();
        end
      end
      seen_edge = 1'b1;
    end
    cyc = cyc + 1;
  end

  // Reset discards everything in flight.
  always @(negedge reset_n) begin
    exp_q.delete();
    bits_q.delete();
    kv = 1'b0;
    seen_edge = 1'b0;
    prev_en = 1'b0;
    model_latch = '0;
  end

  // Monitor: per-cycle timing checks plus scoreboard pop on enable rise.
  always @(negedge clk) begin
    int d;
    bit ee, eb, ed, er;
    if (!reset_n) begin
      chk_b("rst_enable", latch_enable, 1'b0);
      chk_w("rst_latch_D", latch_D, '0);
      chk_b("rst_ready", s_ready, 1'b0);
      chk_b("rst_busy", busy, 1'b0);
      chk_b("rst_done", done, 1'b0);
      prev_en = 1'b0;
    end else begin
      d  = cyc - 1 - last_k;
      ee = kv && d >= S && d < S + E;
      eb = kv && d >= 0 && d < WIN;
      ed = kv && d == WIN;
      er = seen_edge && !eb;
      chk_b("latch_enable", latch_enable, ee);
      chk_b("busy", busy, eb);
      chk_b("done", done, ed);
      chk_b("s_ready", s_ready, er);
      chk_w("latch_D_hold", latch_D, model_latch);
      if (latch_enable && !prev_en) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL enable_rise: got rise expected none (cycle %0d)",
                   cyc);
        end else begin
          chk_w("scoreboard_word", latch_D, exp_q.pop_front());
        end
      end
      prev_en = latch_enable;
    end
  end

  task automatic send_bit(input logic b, input bit gaps);
    bit sent;
    int guard;
    sent = 1'b0;
    guard = 0;
    while (!sent) begin
      @(negedge clk);
      clear = 1'b0;
      if (gaps && $urandom_range(0, 1) == 1) begin
        s_valid = 1'b0;
      end else begin
        s_valid = 1'b1;
        s_data = b;
        sent = s_ready;
      end
      guard++;
      if (guard > 100) begin
        n_chk++;
        $display("FAIL send_bit: got s_ready stuck low expected high");
        sent = 1'b1;
      end
    end
  endtask

  task automatic send_word(input logic [W-1:0] w, input bit gaps);
    for (int i = W - 1; i >= 0; i--) send_bit(w[i], gaps);
  endtask

  task automatic wait_idle(input bit push_ones);
    int g;
    g = 0;
    do begin
      @(negedge clk);
      clear = 1'b0;
      s_valid = push_ones && !s_ready;
      s_data = 1'b1;
      g++;
    end while ((busy || !s_ready) && g < 50);
    s_valid = 1'b0;
    if (g >= 50) begin
      n_chk++;
      $display("FAIL wait_idle: got busy after 50 cycles expected idle");
    end
  endtask

  task automatic wait_enable();
    int g;
    g = 0;
    do begin
      @(negedge clk);
      s_valid = 1'b0;
      g++;
    end while (!latch_enable && g < 30);
    if (!latch_enable) begin
      n_chk++;
      $display("FAIL wait_enable: got 0 expected 1");
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] rw;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b1;

    send_word(8'hA5, 1'b0);
    wait_idle(1'b0);

    send_word(8'hA5, 1'b1);
    wait_idle(1'b1);

    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    @(negedge clk);
    s_valid = 1'b1;
    s_data = 1'b1;
    clear = 1'b1;
    send_word(8'h3C, 1'b0);
    wait_enable();
    clear = 1'b1;
    repeat (2) @(negedge clk);
    clear = 1'b0;
    wait_idle(1'b0);

    send_word(8'h96, 1'b0);
    wait_enable();
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk_b("async_enable", latch_enable, 1'b0);
    chk_w("async_latch_D", latch_D, '0);
    #1 reset_n = 1'b1;
    send_word(8'h5A, 1'b0);
    wait_idle(1'b0);

    send_word(8'hFF, 1'b0);
    send_word(8'h00, 1'b0);
    wait_idle(1'b0);
    chk_i("b2b_spacing", k_hist[$] - k_hist[$-1], W + WIN);

    for (int n = 0; n < 20; n++) begin
      rw = W'($urandom);
      send_word(rw, $urandom_range(0, 1) == 1);
      if ($urandom_range(0, 2) == 0) wait_idle($urandom_range(0, 1) == 1);
    end
    wait_idle(1'b0);
    repeat (5) @(negedge clk);
    chk_i("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
